// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
// The redirect-source encoding doubles as its priority: larger value wins.
package pc_seq_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_0180;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_BR   = 2'd1,
        SRC_JMP  = 2'd2,
        SRC_EXC  = 2'd3
    } redir_src_t;

    function automatic logic [31:0] align4(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port between the PC sequencer and imem.
// Handshake: a fetch completes in any cycle where imem_req && imem_ack; imem_addr
// stays stable while imem_req is high and no ack has been seen.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;

    modport master (output imem_req, output imem_addr, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_redirect_mux.sv
// Priority select of redirect source and word-aligned target: exc > jump > br_taken.
module pc_redirect_mux
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic        exc,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output redir_src_t  src,
    output logic [31:0] target
);

    always_comb begin
        src    = SRC_NONE;
        target = 32'h0;
        if (exc) begin
            src    = SRC_EXC;
            target = align4(EXC_VEC);
        end else if (jump) begin
            src    = SRC_JMP;
            target = align4(jump_target);
        end else if (br_taken) begin
            src    = SRC_BR;
            target = align4(br_target);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer: merges stall/branch/jump/exception
// into one next-PC decision per cycle and drives the imem request handshake.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  stall,
    input  logic                  br_taken,
    input  logic [31:0]           br_target,
    input  logic                  jump,
    input  logic [31:0]           jump_target,
    input  logic                  exc,
    pc_sequencer_if.master        imem,
    output logic [31:0]           pc_out,
    output logic [31:0]           pc_plus4,
    output logic                  if_valid,
    output logic                  flush,
    output logic [31:0]           epc,
    output seq_state_t            state_dbg
);

    seq_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        flush_q, flush_d;
    logic [31:0] tgt_q, tgt_d;
    redir_src_t  tsrc_q, tsrc_d;
    redir_src_t  rsrc;
    logic [31:0] rtgt;
    logic        redir;
    logic        req;

    pc_redirect_mux #(.EXC_VEC(EXC_VEC)) u_mux (
        .exc         (exc),
        .jump        (jump),
        .jump_target (jump_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .src         (rsrc),
        .target      (rtgt)
    );

    assign redir = (rsrc != SRC_NONE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            epc_q   <= 32'h0;
            flush_q <= 1'b0;
            tgt_q   <= 32'h0;
            tsrc_q  <= SRC_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            flush_q <= flush_d;
            tgt_q   <= tgt_d;
            tsrc_q  <= tsrc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        epc_d    = epc_q;
        flush_d  = 1'b0;
        tgt_d    = tgt_q;
        tsrc_d   = tsrc_q;
        req      = 1'b0;
        if_valid = 1'b0;
        if (rsrc == SRC_EXC && !(state_q == DRAIN && tsrc_q == SRC_EXC))
            epc_d = pc_q;
        unique case (state_q)
            IDLE, HOLD: begin
                if (redir) begin
                    pc_d    = rtgt;
                    flush_d = 1'b1;
                    state_d = REQ;
                end else if (state_q == IDLE) begin
                    state_d = REQ;
                end else if (!stall) begin
                    if_valid = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    state_d  = REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (redir) begin
                    flush_d = 1'b1;
                    if (imem.imem_ack) begin
                        pc_d = rtgt;
                    end else begin
                        tgt_d   = rtgt;
                        tsrc_d  = rsrc;
                        state_d = DRAIN;
                    end
                end else if (imem.imem_ack) begin
                    if (stall) begin
                        state_d = HOLD;
                    end else begin
                        if_valid = 1'b1;
                        pc_d     = pc_q + 32'd4;
                    end
                end
            end
            DRAIN: begin
                // Old address stays on the bus until imem answers; its data is dropped.
                req = 1'b1;
                if (rsrc > tsrc_q) begin
                    tgt_d   = rtgt;
                    tsrc_d  = rsrc;
                    flush_d = 1'b1;
                end
                if (imem.imem_ack) begin
                    pc_d    = tgt_d;
                    tsrc_d  = SRC_NONE;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign pc_out         = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign flush          = flush_q;
    assign epc            = epc_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, stall/HOLD, redirect
// priority, exception drain, PC wrap and reset during a drain.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic        flush;
    logic [31:0] epc;
    seq_state_t  state_dbg;

    int checks   = 0;
    int failures = 0;

    pc_sequencer_if imem_bus ();

    pc_sequencer dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .exc         (exc),
        .imem        (imem_bus),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .if_valid    (if_valid),
        .flush       (flush),
        .epc         (epc),
        .state_dbg   (state_dbg)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then let combinational outputs settle.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_redirects();
        br_taken = 1'b0;
        jump     = 1'b0;
        exc      = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        stall = 1'b0;
        br_taken = 1'b0;
        br_target = 32'h0;
        jump = 1'b0;
        jump_target = 32'h0;
        exc = 1'b0;
        imem_bus.imem_ack = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_req", 32'(imem_bus.imem_req), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_ifv", 32'(if_valid), 32'h0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));

        // IDLE cycle: no request even with ack available
        Rst = 1'b0;
        imem_bus.imem_ack = 1'b1;
        settle();
        chk("idle_req", 32'(imem_bus.imem_req), 32'h0);
        tick();

        // Zero-wait fetches: 0, 4
        chk("seq_addr0", imem_bus.imem_addr, 32'h0);
        chk("seq_req0", 32'(imem_bus.imem_req), 32'h1);
        chk("seq_ifv0", 32'(if_valid), 32'h1);
        chk("seq_pc4_0", pc_plus4, 32'h4);
        tick();
        chk("seq_addr4", imem_bus.imem_addr, 32'h4);
        chk("seq_ifv4", 32'(if_valid), 32'h1);
        chk("seq_flush4", 32'(flush), 32'h0);
        tick();

        // Stall with ack at PC=8 -> HOLD for 3 stall cycles
        stall = 1'b1;
        settle();
        chk("stall_addr8", imem_bus.imem_addr, 32'h8);
        chk("stall_ifv_req", 32'(if_valid), 32'h0);
        tick();
        imem_bus.imem_ack = 1'b0;
        settle();
        chk("hold_state", 32'(state_dbg), 32'(HOLD));
        chk("hold_req", 32'(imem_bus.imem_req), 32'h0);
        chk("hold_pc", pc_out, 32'h8);
        chk("hold_ifv", 32'(if_valid), 32'h0);
        tick();
        chk("hold_pc2", pc_out, 32'h8);
        tick();
        stall = 1'b0;
        settle();
        chk("unhold_ifv", 32'(if_valid), 32'h1);
        chk("unhold_req", 32'(imem_bus.imem_req), 32'h0);
        tick();
        imem_bus.imem_ack = 1'b1;
        settle();
        chk("seq_addr12", imem_bus.imem_addr, 32'hC);
        chk("seq_ifv12", 32'(if_valid), 32'h1);
        chk("seq_flush12", 32'(flush), 32'h0);
        tick();

        // Branch and jump together with ack at PC=16: jump wins
        br_taken = 1'b1;
        br_target = 32'h41;
        jump = 1'b1;
        jump_target = 32'h200;
        settle();
        chk("bj_addr16", imem_bus.imem_addr, 32'h10);
        chk("bj_ifv", 32'(if_valid), 32'h0);
        tick();
        clear_redirects();
        settle();
        chk("bj_addr", imem_bus.imem_addr, 32'h200);
        chk("bj_flush", 32'(flush), 32'h1);
        tick();
        chk("bj_flush_end", 32'(flush), 32'h0);
        chk("bj_addr_next", imem_bus.imem_addr, 32'h204);

        // Jump to an unaligned target lands on 0x10
        jump = 1'b1;
        jump_target = 32'h13;
        tick();
        clear_redirects();
        imem_bus.imem_ack = 1'b0;
        settle();
        chk("align_addr", imem_bus.imem_addr, 32'h10);

        // Exception at PC=0x10 with ack delayed: DRAIN
        exc = 1'b1;
        settle();
        chk("exc_req", 32'(imem_bus.imem_req), 32'h1);
        chk("exc_ifv", 32'(if_valid), 32'h0);
        tick();
        clear_redirects();
        settle();
        chk("drain_state", 32'(state_dbg), 32'(DRAIN));
        chk("drain_addr1", imem_bus.imem_addr, 32'h10);
        chk("drain_req", 32'(imem_bus.imem_req), 32'h1);
        chk("drain_flush", 32'(flush), 32'h1);
        chk("drain_epc", epc, 32'h10);
        // Lower-priority branch during drain is ignored
        br_taken = 1'b1;
        br_target = 32'h80;
        tick();
        clear_redirects();
        settle();
        chk("drain_flush_once", 32'(flush), 32'h0);
        chk("drain_addr2", imem_bus.imem_addr, 32'h10);
        imem_bus.imem_ack = 1'b1;
        settle();
        chk("drain_ack_ifv", 32'(if_valid), 32'h0);
        tick();
        chk("exc_vec_addr", imem_bus.imem_addr, 32'h180);
        chk("exc_state_req", 32'(state_dbg), 32'(REQ));
        chk("exc_epc_keep", epc, 32'h10);
        chk("exc_flush_end", 32'(flush), 32'h0);

        // Wrap at top of address space
        jump = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        clear_redirects();
        settle();
        chk("wrap_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        chk("wrap_ifv", 32'(if_valid), 32'h1);
        tick();
        chk("wrap_next", imem_bus.imem_addr, 32'h0);

        // Reset while draining a jump; the late ack must not load the target
        jump = 1'b1;
        jump_target = 32'h300;
        imem_bus.imem_ack = 1'b0;
        tick();
        clear_redirects();
        settle();
        chk("rdrain_state", 32'(state_dbg), 32'(DRAIN));
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        imem_bus.imem_ack = 1'b1;
        settle();
        chk("rdrain_pc", pc_out, 32'h0);
        chk("rdrain_req", 32'(imem_bus.imem_req), 32'h0);
        chk("rdrain_flush", 32'(flush), 32'h0);
        chk("rdrain_epc", epc, 32'h0);
        chk("rdrain_ifv", 32'(if_valid), 32'h0);
        tick();
        chk("rdrain_addr", imem_bus.imem_addr, 32'h0);
        chk("rdrain_req2", 32'(imem_bus.imem_req), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the program counter and sequences instruction fetch for the CPU. It holds the current PC, drives a request/acknowledge handshake to instruction memory, and merges stall, branch, jump and exception requests into a single next-PC decision each cycle. It sits between the hazard/branch logic of the pipeline and the instruction memory port, and it replaces ad-hoc PC hold arithmetic with an explicit state machine.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- EXC_VEC, 32'h0000_0180, exception handler entry address
- Clk  in  1  pipeline clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit requests PC hold
- br_taken  in  1  branch resolved taken this cycle
- br_target  in  32  branch target
- jump  in  1  jump redirect this cycle
- jump_target  in  32  jump target
- exc  in  1  exception redirect this cycle
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (equals pc_out)
- imem_ack  in  1  instruction memory has returned data for imem_addr
- pc_out  out  32  current fetch PC
- pc_plus4  out  32  pc_out + 4, for link/return logic
- if_valid  out  1  fetched instruction is valid and accepted this cycle
- flush  out  1  one-cycle pulse clearing IF/ID on redirect
- epc  out  32  PC of the fetch in flight when exc was taken

## Operation
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: entered on reset; one cycle, no request; then REQ.
- REQ: imem_req=1. On imem_ack && !stall: if_valid=1, pc <= pc+4, stay REQ. On imem_ack && stall: if_valid=0, go HOLD, no PC change. No ack: stay REQ, hold PC.
- HOLD: imem_req=0, PC held. When stall deasserts: if_valid=1, pc <= pc+4, go REQ.
- Redirect priority exc > jump > br_taken; only the highest one is used. Redirects override stall.
- Redirect in IDLE, HOLD, or REQ coincident with imem_ack: pc <= target next cycle, flush=1, go REQ; in-flight data discarded (if_valid=0).
- Redirect in REQ without ack: latch target, flush=1, go DRAIN. DRAIN keeps imem_req=1 on the old address until imem_ack, discards data, then pc <= latched target and goes REQ. A higher-priority redirect during DRAIN overwrites the latched target; a lower one is ignored. Each accepted redirect pulses flush for exactly one cycle.
- exc sets epc <= pc_out in the same cycle the redirect is accepted.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). Targets have bits[1:0] forced to 0.

## Timing
- Reset: pc_out=RESET_PC, state IDLE, imem_req=0, if_valid=0, flush=0, epc=0; a reset during any state, including DRAIN, abandons the outstanding fetch.
- imem_req and if_valid are decoded combinationally from the state and inputs. pc_out, epc and flush are registered.
- Zero-wait memory (ack in the same cycle as req) gives one instruction per cycle. The first request is issued in cycle 2 after reset deassertion.
- Redirect latency: the target appears on imem_addr 1 cycle after acceptance, or 1 cycle after the draining ack.
- stall together with no ack in REQ: the request stays asserted and the address is stable.

## Structure
- Shared package pc_seq_pkg holds:
  - the state enum (IDLE/REQ/HOLD/DRAIN)
  - the redirect-source encoding (NONE/BR/JMP/EXC)
  - default RESET_PC and EXC_VEC constants
- One sub-module, pc_redirect_mux: a combinational priority select of source and aligned target from exc/jump/br_taken. The FSM and registers stay in pc_sequencer.

## Test plan
- Reset then zero-wait ack for 4 cycles -> imem_addr 0,4,8,12; if_valid high from the first ack; flush never asserted.
- stall high for 3 cycles with ack at PC=8 -> HOLD; PC stays 8; if_valid low; when stall drops, if_valid=1 and next addr=12.
- br_taken(br_target=0x41) and jump(jump_target=0x200) in the same cycle with ack -> next addr 0x200; flush pulse of 1 cycle.
- exc at PC=0x10 with ack delayed 3 cycles -> DRAIN; imem_addr holds 0x10 until ack; then 0x180; epc=0x10.
- PC=0xFFFF_FFFC with ack -> next addr 0x0000_0000.
- Rst asserted in DRAIN -> next cycle pc_out=RESET_PC, imem_req=0, flush=0; the late ack is ignored.
